phys_reg_free_list: RTL and testbench



---
 rtl/phys_reg_free_list.sv | 82 ++++++++
 tb/tb_phys_reg_free_list.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags for rename, with checkpointed
// head pointers so a mispredict restore reclaims speculative allocations in one cycle.
module phys_reg_free_list #(
  parameter int FREE_LIST_DEPTH        = 32,
  parameter int LOG_FREE_LIST_DEPTH    = 5,
  parameter int CHECKPOINT_COLUMNS     = 4,
  parameter int LOG_CHECKPOINT_COLUMNS = 2,
  parameter int PHYS_REG_WIDTH         = 6
) (
  input  logic                              CLK,
  input  logic                              nRST,
  input  logic                              dequeue_req,
  output logic                              dequeue_valid,
  output logic [PHYS_REG_WIDTH-1:0]         dequeue_phys_reg_tag,
  input  logic                              enqueue_valid,
  input  logic [PHYS_REG_WIDTH-1:0]         enqueue_phys_reg_tag,
  input  logic                              save_valid,
  input  logic [LOG_CHECKPOINT_COLUMNS-1:0] save_column,
  input  logic                              restore_valid,
  input  logic [LOG_CHECKPOINT_COLUMNS-1:0] restore_column,
  output logic [LOG_FREE_LIST_DEPTH:0]      free_count,
  output logic                              empty,
  output logic                              full
);

  localparam int PW = LOG_FREE_LIST_DEPTH + 1;

  logic [PHYS_REG_WIDTH-1:0] entry_q [FREE_LIST_DEPTH];
  logic [PW-1:0]             saved_q [CHECKPOINT_COLUMNS];
  logic [PW-1:0]             head_q, head_d;
  logic [PW-1:0]             tail_q, tail_d;
  logic                      deq_eff;
  logic                      enq_eff;

  assign free_count = tail_q - head_q;
  assign empty      = (head_q == tail_q);
  assign full       = (head_q[PW-2:0] == tail_q[PW-2:0]) && (head_q[PW-1] != tail_q[PW-1]);

  assign dequeue_valid        = !empty;
  assign dequeue_phys_reg_tag = entry_q[head_q[PW-2:0]];

  // Restore owns the head this cycle, so a concurrent dequeue is dropped.
  assign deq_eff = dequeue_req && !empty && !restore_valid;
  assign enq_eff = enqueue_valid && !full;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (restore_valid) begin
      head_d = saved_q[restore_column];
    end else if (deq_eff) begin
      head_d = head_q + PW'(1);
    end
    if (enq_eff) begin
      tail_d = tail_q + PW'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < FREE_LIST_DEPTH; i++) begin
        entry_q[i] <= PHYS_REG_WIDTH'(FREE_LIST_DEPTH + i);
      end
      for (int c = 0; c < CHECKPOINT_COLUMNS; c++) begin
        saved_q[c] <= '0;
      end
      head_q <= '0;
      tail_q <= PW'(FREE_LIST_DEPTH);
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      if (enq_eff) begin
        entry_q[tail_q[PW-2:0]] <= enqueue_phys_reg_tag;
      end
      // Checkpoint the post-dequeue head so the branch keeps its own allocation.
      if (save_valid && !restore_valid) begin
        saved_q[save_column] <= head_d;
      end
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Self-checking bench for phys_reg_free_list: directed table, hand sequences,
// and randomized traffic against an unbounded-counter reference model.
module tb_phys_reg_free_list;

  logic       CLK;
  logic       nRST;
  logic       dequeue_req;
  logic       dequeue_valid;
  logic [5:0] dequeue_phys_reg_tag;
  logic       enqueue_valid;
  logic [5:0] enqueue_phys_reg_tag;
  logic       save_valid;
  logic [1:0] save_column;
  logic       restore_valid;
  logic [1:0] restore_column;
  logic [5:0] free_count;
  logic       empty;
  logic       full;

  int n_chk  = 0;
  int n_fail = 0;

  phys_reg_free_list dut (
    .CLK                 (CLK),
    .nRST                (nRST),
    .dequeue_req         (dequeue_req),
    .dequeue_valid       (dequeue_valid),
    .dequeue_phys_reg_tag(dequeue_phys_reg_tag),
    .enqueue_valid       (enqueue_valid),
    .enqueue_phys_reg_tag(enqueue_phys_reg_tag),
    .save_valid          (save_valid),
    .save_column         (save_column),
    .restore_valid       (restore_valid),
    .restore_column      (restore_column),
    .free_count          (free_count),
    .empty               (empty),
    .full                (full)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit       deq;
    bit       enq;
    bit [5:0] tag;
    bit       save;
    bit [1:0] scol;
    bit       rest;
    bit [1:0] rcol;
    int       etag;
    int       ecnt;
    bit       eemp;
    bit       efull;
  } vec_t;

  vec_t vec [10];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string nm, input int etag, input int ecnt, input bit eemp,
                         input bit efull);
    chk({nm, ".tag"}, int'(dequeue_phys_reg_tag), etag);
    chk({nm, ".count"}, int'(free_count), ecnt);
    chk({nm, ".empty"}, int'(empty), int'(eemp));
    chk({nm, ".full"}, int'(full), int'(efull));
    chk({nm, ".valid"}, int'(dequeue_valid), int'(!eemp));
  endtask

  task automatic idle();
    dequeue_req          = 1'b0;
    enqueue_valid        = 1'b0;
    enqueue_phys_reg_tag = '0;
    save_valid           = 1'b0;
    save_column          = '0;
    restore_valid        = 1'b0;
    restore_column       = '0;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    idle();
    @(negedge CLK);
    nRST = 1'b0;
    #2;
    nRST = 1'b1;
  endtask

  // Reference model: head/tail as ever-growing counts, entries indexed mod 32.
  int mh, mt;
  int ms [4];
  int mm [32];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mm[i] = 32 + i;
    for (int c = 0; c < 4; c++) ms[c] = 0;
    mh = 0;
    mt = 32;
  endtask

  initial begin
    nRST = 1'b1;
    idle();
    #1 nRST = 1'b0;

    vec[0] = '{1, 0, 0, 0, 0, 0, 0, 33, 31, 0, 0};
    vec[1] = '{1, 0, 0, 0, 0, 0, 0, 34, 30, 0, 0};
    vec[2] = '{1, 0, 0, 0, 0, 0, 0, 35, 29, 0, 0};
    vec[3] = '{1, 0, 0, 1, 2, 0, 0, 36, 28, 0, 0};
    vec[4] = '{1, 0, 0, 0, 0, 0, 0, 37, 27, 0, 0};
    vec[5] = '{1, 0, 0, 0, 0, 0, 0, 38, 26, 0, 0};
    vec[6] = '{0, 0, 0, 0, 0, 1, 2, 36, 28, 0, 0};
    vec[7] = '{1, 0, 0, 1, 1, 0, 0, 37, 27, 0, 0};
    vec[8] = '{1, 0, 0, 0, 0, 0, 0, 38, 26, 0, 0};
    vec[9] = '{1, 1, 7, 0, 0, 1, 1, 37, 28, 0, 0};

    // Drain the full list, then refill across the wrap point.
    do_reset();
    chk_out("reset", 32, 32, 0, 1);
    dequeue_req = 1'b1;
    for (int i = 0; i < 32; i++) begin
      chk("drain.tag", int'(dequeue_phys_reg_tag), 32 + i);
      cyc();
    end
    chk_out("drained", 32, 0, 1, 0);
    cyc();
    chk_out("deq_on_empty", 32, 0, 1, 0);
    dequeue_req          = 1'b0;
    enqueue_valid        = 1'b1;
    enqueue_phys_reg_tag = 6'd5;
    save_valid           = 1'b1;
    save_column          = 2'd3;
    cyc();
    save_valid = 1'b0;
    chk_out("enq5", 5, 1, 0, 0);
    enqueue_phys_reg_tag = 6'd9;
    cyc();
    enqueue_valid = 1'b0;
    chk_out("enq9", 5, 2, 0, 0);
    dequeue_req = 1'b1;
    cyc();
    chk_out("deq5", 9, 1, 0, 0);
    enqueue_valid        = 1'b1;
    enqueue_phys_reg_tag = 6'd7;
    restore_valid        = 1'b1;
    restore_column       = 2'd3;
    cyc();
    enqueue_valid = 1'b0;
    restore_valid = 1'b0;
    chk_out("rest_enq7", 5, 3, 0, 0);
    cyc();
    chk_out("post_rest1", 9, 2, 0, 0);
    cyc();
    chk_out("post_rest2", 7, 1, 0, 0);
    cyc();
    chk("post_rest3.count", int'(free_count), 0);
    chk("post_rest3.empty", int'(empty), 1);
    idle();

    // Checkpoint/restore table from reset.
    do_reset();
    for (int v = 0; v < 10; v++) begin
      dequeue_req          = vec[v].deq;
      enqueue_valid        = vec[v].enq;
      enqueue_phys_reg_tag = vec[v].tag;
      save_valid           = vec[v].save;
      save_column          = vec[v].scol;
      restore_valid        = vec[v].rest;
      restore_column       = vec[v].rcol;
      cyc();
      chk_out($sformatf("vec%0d", v), vec[v].etag, vec[v].ecnt, vec[v].eemp, vec[v].efull);
    end
    idle();

    // Dequeue and enqueue together while full: only the dequeue lands.
    do_reset();
    dequeue_req          = 1'b1;
    enqueue_valid        = 1'b1;
    enqueue_phys_reg_tag = 6'd11;
    cyc();
    idle();
    chk_out("full_deq_enq", 33, 31, 0, 0);

    // Asynchronous reset mid-sequence clears head, tail and every checkpoint.
    do_reset();
    dequeue_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      save_valid  = (i >= 6);
      save_column = 2'(i % 4);
      cyc();
    end
    idle();
    chk("pre_rst.count", int'(free_count), 22);
    #2 nRST = 1'b0;
    #1;
    chk_out("async_rst", 32, 32, 0, 1);
    #1 nRST = 1'b1;
    for (int c = 0; c < 4; c++) begin
      restore_valid  = 1'b1;
      restore_column = 2'(c);
      cyc();
      chk_out($sformatf("saved%0d_zero", c), 32, 32, 0, 1);
    end
    idle();

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      bit       d, e, s, r;
      bit [5:0] t;
      bit [1:0] sc, rc;
      int       nh;
      d  = ($urandom % 2) == 0;
      e  = ($urandom % 2) == 0;
      t  = 6'($urandom);
      s  = ($urandom % 4) == 0;
      sc = 2'($urandom);
      r  = ($urandom % 8) == 0;
      rc = 2'($urandom);
      if (r && !(ms[rc] <= mh && mt - ms[rc] < 32)) r = 1'b0;
      dequeue_req          = d;
      enqueue_valid        = e;
      enqueue_phys_reg_tag = t;
      save_valid           = s;
      save_column          = sc;
      restore_valid        = r;
      restore_column       = rc;
      if (r) nh = ms[rc];
      else if (d && mt != mh) nh = mh + 1;
      else nh = mh;
      if (e && (mt - mh) != 32) begin
        mm[mt % 32] = int'(t);
        mt++;
      end
      if (s && !r) ms[sc] = nh;
      mh = nh;
      cyc();
      chk_out("rand", mm[mh % 32], mt - mh, mt == mh, (mt - mh) == 32);
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
